ula_multiciclo: RTL and testbench

//  Parametrised ALU for the Lapido core with valid/ready handshake and registered outputs.

---
 rtl/ula_multiciclo.sv | 216 +++++++++++++++++++++
 tb/tb_ula_multiciclo.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ula_multiciclo.sv
// rtl/ula_multiciclo.sv - ALU with single-cycle ops plus iterative shift-add multiply and restoring divide
// Registered result held under a valid/ready handshake; in_ready only while idle.
module ula_multiciclo #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic [4:0]       Flag
);

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b00001;
  localparam logic [4:0] OP_AND   = 5'b00010;
  localparam logic [4:0] OP_OR    = 5'b00011;
  localparam logic [4:0] OP_XOR   = 5'b00100;
  localparam logic [4:0] OP_NOT   = 5'b00101;
  localparam logic [4:0] OP_SLL   = 5'b00110;
  localparam logic [4:0] OP_SRL   = 5'b00111;
  localparam logic [4:0] OP_SRA   = 5'b01000;
  localparam logic [4:0] OP_SLT   = 5'b01001;
  localparam logic [4:0] OP_SLTU  = 5'b01010;
  localparam logic [4:0] OP_PASSB = 5'b01011;
  localparam logic [4:0] OP_MUL   = 5'b01100;
  localparam logic [4:0] OP_MULHU = 5'b01101;
  localparam logic [4:0] OP_DIVU  = 5'b01110;
  localparam logic [4:0] OP_REMU  = 5'b01111;

  localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY_MUL, BUSY_DIV, DONE} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opnd;
  logic [SHW-1:0]   cnt;
  logic             sel_hi;

  logic             start_mul;
  logic             start_div;
  logic             last_iter;

  logic [WIDTH:0]   sum_add;
  logic [WIDTH:0]   sum_sub;
  logic [WIDTH-1:0] sc_res;
  logic             sc_err;
  logic             sc_dz;
  logic             sc_v;
  logic             sc_c;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] hi_n;
  logic [WIDTH-1:0] lo_n;
  logic [WIDTH-1:0] it_res;
  logic             it_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    start_mul  = (opcode == OP_MUL) || (opcode == OP_MULHU);
    start_div  = ((opcode == OP_DIVU) || (opcode == OP_REMU)) && (B != '0);
    last_iter  = (cnt == LAST_ITER);
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (start_mul) begin
            state_next = BUSY_MUL;
          end else if (start_div) begin
            state_next = BUSY_DIV;
          end else begin
            state_next = DONE;
          end
        end
      end
      BUSY_MUL, BUSY_DIV: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Single-cycle result, also covers illegal opcodes and divide-by-zero.
  always_comb begin
    sum_add = {1'b0, A} + {1'b0, B};
    sum_sub = {1'b0, A} - {1'b0, B};
    sc_res  = '0;
    sc_err  = 1'b0;
    sc_dz   = 1'b0;
    sc_v    = 1'b0;
    sc_c    = 1'b0;
    case (opcode)
      OP_ADD: begin
        sc_res = sum_add[WIDTH-1:0];
        sc_c   = sum_add[WIDTH];
        sc_v   = (A[WIDTH-1] == B[WIDTH-1]) && (sum_add[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = sum_sub[WIDTH-1:0];
        sc_c   = ~sum_sub[WIDTH];
        sc_v   = (A[WIDTH-1] != B[WIDTH-1]) && (sum_sub[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:   sc_res = A & B;
      OP_OR:    sc_res = A | B;
      OP_XOR:   sc_res = A ^ B;
      OP_NOT:   sc_res = ~A;
      OP_SLL:   sc_res = A << B[SHW-1:0];
      OP_SRL:   sc_res = A >> B[SHW-1:0];
      OP_SRA:   sc_res = $unsigned($signed(A) >>> B[SHW-1:0]);
      OP_SLT:   sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU:  sc_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_PASSB: sc_res = B;
      OP_MUL, OP_MULHU: sc_res = '0;
      OP_DIVU: begin
        sc_res = '1;
        sc_dz  = 1'b1;
      end
      OP_REMU: begin
        sc_res = A;
        sc_dz  = 1'b1;
      end
      default: sc_err = 1'b1;
    endcase
  end

  // One iteration step; {hi,lo} is product for multiply, {remainder,quotient} for divide.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    div_shift = {hi, lo[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd};
    div_diff  = div_shift[WIDTH-1:0] - opnd;
    if (state == BUSY_MUL) begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], lo[WIDTH-1:1]};
    end else begin
      hi_n = div_ge ? div_diff : div_shift[WIDTH-1:0];
      lo_n = {lo[WIDTH-2:0], div_ge};
    end
    it_res = sel_hi ? hi_n : lo_n;
    it_c   = (state == BUSY_MUL) && !sel_hi && (hi_n != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi     <= '0;
      lo     <= '0;
      opnd   <= '0;
      cnt    <= '0;
      sel_hi <= 1'b0;
      Out    <= '0;
      Flag   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt    <= '0;
            sel_hi <= opcode[0];
            if (start_mul) begin
              hi   <= '0;
              lo   <= B;
              opnd <= A;
            end else if (start_div) begin
              hi   <= '0;
              lo   <= A;
              opnd <= B;
            end else begin
              Out  <= sc_res;
              Flag <= {sc_err, sc_dz, sc_v, sc_c, sc_res[WIDTH-1]};
            end
          end
        end
        BUSY_MUL, BUSY_DIV: begin
          hi  <= hi_n;
          lo  <= lo_n;
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            Out  <= it_res;
            Flag <= {3'b000, it_c, it_res[WIDTH-1]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_multiciclo.sv
// tb/tb_ula_multiciclo.sv - directed bench for ula_multiciclo against an arithmetic reference model
module tb_ula_multiciclo;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  opcode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Out;
  logic [4:0]  Flag;

  int cmp_cnt = 0;
  int err_cnt = 0;

  logic        inflight = 1'b0;
  logic        seen = 1'b0;
  int          since_acc = 0;
  int          m_lat = 0;
  logic [31:0] m_out = '0;
  logic [4:0]  m_flag = '0;

  ula_multiciclo #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .Out(Out), .Flag(Flag)
  );

  always #5 clk = ~clk;

  // Returns {err, dz, V, C, N, result}.
  function automatic logic [36:0] model(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
    logic [31:0] r;
    logic [63:0] p;
    longint      s;
    logic        err, dz, v, c;
    r = '0; err = 0; dz = 0; v = 0; c = 0;
    p = 64'(a) * 64'(b);
    case (op)
      5'd0: begin
        s = longint'($signed(a)) + longint'($signed(b));
        r = a + b;
        c = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      5'd1: begin
        s = longint'($signed(a)) - longint'($signed(b));
        r = a - b;
        c = (a >= b);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      5'd2:  r = a & b;
      5'd3:  r = a | b;
      5'd4:  r = a ^ b;
      5'd5:  r = ~a;
      5'd6:  r = a << b[4:0];
      5'd7:  r = a >> b[4:0];
      5'd8:  r = $unsigned($signed(a) >>> b[4:0]);
      5'd9:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd10: r = (a < b) ? 32'd1 : 32'd0;
      5'd11: r = b;
      5'd12: begin r = p[31:0]; c = (p[63:32] != 0); end
      5'd13: r = p[63:32];
      5'd14: begin
        if (b == 0) begin r = 32'hFFFF_FFFF; dz = 1; end
        else r = a / b;
      end
      5'd15: begin
        if (b == 0) begin r = a; dz = 1; end
        else r = a % b;
      end
      default: err = 1;
    endcase
    return {err, dz, v, c, r[31], r};
  endfunction

  function automatic int model_lat(input logic [31:0] b, input logic [4:0] op);
    if (op == 5'd12 || op == 5'd13) return 33;
    if ((op == 5'd14 || op == 5'd15) && b != 0) return 33;
    return 1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    if (inflight) begin
      check("in_ready_busy", in_ready, 0);
      if (!seen) since_acc++;
      if (out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          check("latency", since_acc, m_lat);
        end
        check("out", Out, m_out);
        check("flag", Flag, m_flag);
      end
    end else begin
      check("idle_out_valid", out_valid, 0);
      check("idle_in_ready", in_ready, 1);
    end
  end

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                          input logic [31:0] lit_out, input logic [4:0] lit_flag, input bit early);
    logic [36:0] m;
    int guard;
    m = model(a, b, op);
    check("model_pin_out", m[31:0], lit_out);
    check("model_pin_flag", m[36:32], lit_flag);
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_before_accept", in_ready, 1);
    A = a; B = b; opcode = op; in_valid = 1'b1; out_ready = early;
    @(posedge clk);
    m_out = m[31:0]; m_flag = m[36:32]; m_lat = model_lat(b, op);
    since_acc = 0; seen = 1'b0; inflight = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    A = $urandom; B = $urandom; opcode = 5'($urandom);
  endtask

  task automatic finish_op(input int hold);
    int guard;
    guard = 0;
    while (!out_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!out_valid) begin
      check("result_timeout", 0, 1);
      #2 inflight = 1'b0; reset = 1'b1;
      @(negedge clk);
      #2 reset = 1'b0;
      return;
    end
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    inflight = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                     input logic [31:0] lit_out, input logic [4:0] lit_flag, input bit early, input int hold);
    start_op(a, b, op, lit_out, lit_flag, early);
    finish_op(hold);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench time limit");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; opcode = '0;
    repeat (2) @(negedge clk);
    check("reset_out", Out, 0);
    check("reset_flag", Flag, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    reset = 1'b0;

    // flag = {err, dz, V, C, N}
    run(32'h1,        32'h0,        5'd0,  32'h1,        5'b00000, 0, 0);
    run(32'h7FFFFFFF, 32'h1,        5'd0,  32'h80000000, 5'b00101, 0, 0);
    run(32'hFFFFFFFF, 32'h1,        5'd0,  32'h0,        5'b00010, 0, 0);
    run(32'h0,        32'h1,        5'd1,  32'hFFFFFFFF, 5'b00001, 0, 0);
    run(32'h5,        32'h3,        5'd1,  32'h2,        5'b00010, 0, 0);
    run(32'h80000000, 32'h1,        5'd1,  32'h7FFFFFFF, 5'b00110, 0, 0);
    run(32'hF0F0F0F0, 32'hFF00FF00, 5'd2,  32'hF000F000, 5'b00001, 0, 0);
    run(32'h0F0F0000, 32'h000000F0, 5'd3,  32'h0F0F00F0, 5'b00000, 0, 0);
    run(32'hFFFF0000, 32'hFF00FF00, 5'd4,  32'h00FFFF00, 5'b00000, 0, 0);
    run(32'h0,        32'h12345678, 5'd5,  32'hFFFFFFFF, 5'b00001, 0, 0);
    run(32'h1,        32'd31,       5'd6,  32'h80000000, 5'b00001, 0, 0);
    run(32'h1234,     32'h20,       5'd6,  32'h1234,     5'b00000, 0, 0);
    run(32'h80000000, 32'h4,        5'd7,  32'h08000000, 5'b00000, 0, 0);
    run(32'h80000000, 32'h4,        5'd8,  32'hF8000000, 5'b00001, 0, 0);
    run(32'hFFFFFFFF, 32'h1,        5'd9,  32'h1,        5'b00000, 0, 0);
    run(32'hFFFFFFFF, 32'h1,        5'd10, 32'h0,        5'b00000, 0, 0);
    run(32'h0,        32'hDEADBEEF, 5'd11, 32'hDEADBEEF, 5'b00001, 0, 0);
    run(32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 32'h00000001, 5'b00010, 0, 10);
    run(32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13, 32'hFFFFFFFE, 5'b00001, 0, 0);
    run(32'h3,        32'h5,        5'd12, 32'hF,        5'b00000, 1, 0);
    run(32'h100,      32'h7,        5'd14, 32'h24,       5'b00000, 0, 0);
    run(32'h100,      32'h7,        5'd15, 32'h4,        5'b00000, 0, 3);
    run(32'hFFFFFFFF, 32'h1,        5'd14, 32'hFFFFFFFF, 5'b00001, 1, 0);
    run(32'h5,        32'h0,        5'd14, 32'hFFFFFFFF, 5'b01001, 0, 0);
    run(32'h1234,     32'h0,        5'd15, 32'h1234,     5'b01000, 0, 0);
    run(32'h55,       32'h66,       5'b10011, 32'h0,     5'b10000, 0, 2);

    // abort a divide midway through its iterations
    start_op(32'h100, 32'h7, 5'd14, 32'h24, 5'b00000, 0);
    repeat (15) @(negedge clk);
    #2 inflight = 1'b0; reset = 1'b1;
    #1;
    check("abort_out", Out, 0);
    check("abort_flag", Flag, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    @(negedge clk);
    #2 reset = 1'b0;

    run(32'h2,        32'h3,        5'd0,  32'h5,        5'b00000, 0, 0);
    run(32'h64,       32'hA,        5'd15, 32'h0,        5'b00000, 0, 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
